layer1_accumulator: RTL and testbench

Downstream stage of the layer-1 3x3 convolution MAC array. Each cycle it accepts one kernel-tap partial sum per output channel (8 channels, Q6.10 signed). It accumulates 9 taps per output pixel, adds a per-channel bias, applies optional ReLU and saturation, and presents one packed 8-channel pixel to the layer-1 output buffer over a valid/ready handshake. It also counts pixels and flags the end of the layer.

---
 rtl/layer1_pkg.sv | 15 +
 rtl/layer1_accumulator_if.sv | 30 +++
 rtl/layer1_acc_lane.sv | 60 ++++++
 rtl/layer1_accumulator.sv | 113 +++++++++++
 tb/tb_layer1_accumulator.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/layer1_pkg.sv
// rtl/layer1_pkg.sv - shared constants and state type for the layer-1 accumulator
package layer1_pkg;
    localparam int WORDLENGTH  = 16;
    localparam int KERNEL_TAPS = 9;
    localparam int ACC_WIDTH   = 21;
    localparam int OUT_PIXELS  = 900;
    localparam int FRAC_BITS   = 10;
    localparam int CHANNELS    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;
endpackage

// File: rtl/layer1_accumulator_if.sv
// rtl/layer1_accumulator_if.sv - tap input and pixel output handshake bundle
interface layer1_accumulator_if;
    import layer1_pkg::*;

    logic                            in_valid;
    logic                            in_ready;
    logic signed [WORDLENGTH-1:0]    in_channel1;
    logic signed [WORDLENGTH-1:0]    in_channel2;
    logic signed [WORDLENGTH-1:0]    in_channel3;
    logic signed [WORDLENGTH-1:0]    in_channel4;
    logic signed [WORDLENGTH-1:0]    in_channel5;
    logic signed [WORDLENGTH-1:0]    in_channel6;
    logic signed [WORDLENGTH-1:0]    in_channel7;
    logic signed [WORDLENGTH-1:0]    in_channel8;
    logic                            out_valid;
    logic                            out_ready;
    logic [CHANNELS*WORDLENGTH-1:0]  out_data;

    modport master (
        output in_valid, in_channel1, in_channel2, in_channel3, in_channel4,
               in_channel5, in_channel6, in_channel7, in_channel8, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_channel1, in_channel2, in_channel3, in_channel4,
               in_channel5, in_channel6, in_channel7, in_channel8, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/layer1_acc_lane.sv
// rtl/layer1_acc_lane.sv - one channel: tap accumulation, bias add, ReLU/saturation
module layer1_acc_lane
    import layer1_pkg::*;
#(
    parameter bit RELU_EN = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         first,
    input  logic                         add,
    input  logic                         last,
    input  logic signed [WORDLENGTH-1:0] data,
    input  logic signed [WORDLENGTH-1:0] bias,
    output logic signed [WORDLENGTH-1:0] result
);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (WORDLENGTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(2 ** (WORDLENGTH - 1)));

    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  data_ext;
    logic signed [ACC_WIDTH-1:0]  bias_ext;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic signed [WORDLENGTH-1:0] sat;

    assign data_ext = ACC_WIDTH'(data);
    assign bias_ext = ACC_WIDTH'(bias);
    assign sum      = acc + data_ext + bias_ext;

    // Accumulator headroom guarantees sum never wraps, so plain compares are safe
    always_comb begin
        sat = sum[WORDLENGTH-1:0];
        if (RELU_EN && sum[ACC_WIDTH-1]) begin
            sat = '0;
        end else if (sum > SAT_MAX) begin
            sat = SAT_MAX[WORDLENGTH-1:0];
        end else if (sum < SAT_MIN) begin
            sat = SAT_MIN[WORDLENGTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            result <= '0;
        end else if (clear) begin
            acc    <= '0;
            result <= '0;
        end else begin
            if (first) begin
                acc <= data_ext;
            end else if (add) begin
                acc <= acc + data_ext;
            end
            if (last) begin
                result <= sat;
            end
        end
    end
endmodule

// File: rtl/layer1_accumulator.sv
// rtl/layer1_accumulator.sv - 9-tap, 8-channel pixel accumulator with pixel/layer counting
module layer1_accumulator
    import layer1_pkg::*;
#(
    parameter bit RELU_EN = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    layer1_accumulator_if.slave            bus,
    input  logic [CHANNELS*WORDLENGTH-1:0] bias,
    output logic [9:0]                     pixel_cnt,
    output logic                           layer_done
);
    state_t                       state;
    state_t                       next_state;
    logic [3:0]                   tap_cnt;
    logic                         accept;
    logic                         first_beat;
    logic                         last_beat;
    logic                         mid_beat;
    logic                         handshake;
    logic signed [WORDLENGTH-1:0] chan     [CHANNELS];
    logic signed [WORDLENGTH-1:0] lane_out [CHANNELS];

    assign chan[0] = bus.in_channel1;
    assign chan[1] = bus.in_channel2;
    assign chan[2] = bus.in_channel3;
    assign chan[3] = bus.in_channel4;
    assign chan[4] = bus.in_channel5;
    assign chan[5] = bus.in_channel6;
    assign chan[6] = bus.in_channel7;
    assign chan[7] = bus.in_channel8;

    assign bus.in_ready  = (state != HOLD);
    assign bus.out_valid = (state == HOLD);
    assign accept        = bus.in_valid && bus.in_ready;
    assign first_beat    = accept && (tap_cnt == 4'd0);
    assign last_beat     = accept && (tap_cnt == 4'(KERNEL_TAPS - 1));
    assign mid_beat      = accept && !first_beat && !last_beat;
    assign handshake     = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept)        next_state = ACCUM;
                ACCUM:   if (last_beat)     next_state = HOLD;
                HOLD:    if (bus.out_ready) next_state = IDLE;
                default:                    next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tap_cnt    <= '0;
            pixel_cnt  <= '0;
            layer_done <= 1'b0;
        end else if (clear) begin
            tap_cnt    <= '0;
            pixel_cnt  <= '0;
            layer_done <= 1'b0;
        end else begin
            layer_done <= 1'b0;
            if (last_beat) begin
                tap_cnt <= '0;
            end else if (accept) begin
                tap_cnt <= tap_cnt + 4'd1;
            end
            if (handshake) begin
                if (pixel_cnt == 10'(OUT_PIXELS - 1)) begin
                    pixel_cnt  <= '0;
                    layer_done <= 1'b1;
                end else begin
                    pixel_cnt <= pixel_cnt + 10'd1;
                end
            end
        end
    end

    // Channel 1 occupies the most significant word of both bias and out_data
    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        layer1_acc_lane #(.RELU_EN(RELU_EN)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .clear  (clear),
            .first  (first_beat),
            .add    (mid_beat),
            .last   (last_beat),
            .data   (chan[k]),
            .bias   (bias[(CHANNELS-k)*WORDLENGTH-1 -: WORDLENGTH]),
            .result (lane_out[k])
        );
    end

    always_comb begin
        bus.out_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            bus.out_data[(CHANNELS-k)*WORDLENGTH-1 -: WORDLENGTH] = lane_out[k];
        end
    end
endmodule

// File: tb/tb_layer1_accumulator.sv
// tb/tb_layer1_accumulator.sv - randomized scoreboard bench for layer1_accumulator
module tb_layer1_accumulator;
    localparam bit RELU = 1'b1;

    logic         clk = 1'b0;
    logic         rst;
    logic         clear;
    logic [127:0] bias;
    logic [9:0]   pixel_cnt;
    logic         layer_done;
    logic [15:0]  tb_ch [8];

    int total = 0;
    int bad   = 0;

    logic [127:0] q[$];
    int  exp_cnt   = 0;
    bit  exp_done  = 0;
    int  done_seen = 0;

    int  m_acc [8];
    int  m_taps = 0;
    bit  m_hold = 0;

    layer1_accumulator_if bus();

    assign bus.in_channel1 = tb_ch[0];
    assign bus.in_channel2 = tb_ch[1];
    assign bus.in_channel3 = tb_ch[2];
    assign bus.in_channel4 = tb_ch[3];
    assign bus.in_channel5 = tb_ch[4];
    assign bus.in_channel6 = tb_ch[5];
    assign bus.in_channel7 = tb_ch[6];
    assign bus.in_channel8 = tb_ch[7];

    layer1_accumulator #(.RELU_EN(RELU)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .bus        (bus),
        .bias       (bias),
        .pixel_cnt  (pixel_cnt),
        .layer_done (layer_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp(input int s);
        if (RELU && s < 0) return 0;
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return s;
    endfunction

    // Reference model: decides acceptance from its own hold flag, pushes finished pixels
    always @(negedge clk) begin
        #1;
        if (!rst || clear) begin
            m_taps = 0;
            m_hold = 0;
            for (int k = 0; k < 8; k++) m_acc[k] = 0;
            q.delete();
        end else begin
            bit h;
            h = m_hold;
            if (m_hold && bus.out_ready) m_hold = 0;
            if (bus.in_valid && !h) begin
                for (int k = 0; k < 8; k++) m_acc[k] += int'($signed(tb_ch[k]));
                m_taps++;
                if (m_taps == 9) begin
                    logic [127:0] w;
                    for (int k = 0; k < 8; k++) begin
                        int s;
                        s = m_acc[k] + int'($signed(bias[(7-k)*16 +: 16]));
                        w[(7-k)*16 +: 16] = 16'(clamp(s));
                        m_acc[k] = 0;
                    end
                    q.push_back(w);
                    m_hold = 1;
                    m_taps = 0;
                end
            end
        end
    end

    // Output monitor: compares DUT outputs against the scoreboard head and pixel count model
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
            chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
            chk("rst_out_data", bus.out_data, 128'(0));
            chk("rst_pixel_cnt", 128'(pixel_cnt), 128'(0));
            chk("rst_layer_done", 128'(layer_done), 128'(0));
            exp_cnt  = 0;
            exp_done = 0;
        end else begin
            bit ev;
            ev = (q.size() != 0);
            chk("out_valid", 128'(bus.out_valid), 128'(ev));
            chk("in_ready", 128'(bus.in_ready), 128'(!ev));
            if (ev && bus.out_valid) chk("out_data", bus.out_data, q[0]);
            chk("pixel_cnt", 128'(pixel_cnt), 128'(exp_cnt));
            chk("layer_done", 128'(layer_done), 128'(exp_done));
            if (layer_done) done_seen++;
            exp_done = 0;
            if (clear) begin
                exp_cnt = 0;
            end else if (ev && bus.out_ready) begin
                void'(q.pop_front());
                if (exp_cnt == 899) begin
                    exp_cnt  = 0;
                    exp_done = 1;
                end else begin
                    exp_cnt++;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [127:0] w);
        int guard;
        bit ok;
        guard = 0;
        ok    = 0;
        for (int k = 0; k < 8; k++) tb_ch[k] = w[(7-k)*16 +: 16];
        bus.in_valid = 1'b1;
        while (!ok && guard < 100) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            if (!ok) begin
                bus.out_ready = 1'b1;
                guard++;
            end
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL beat_timeout actual=stalled required=accepted at %0t", $time);
        end
    endtask

    task automatic send_n(input int n, input logic [127:0] w);
        for (int i = 0; i < n; i++) send_beat(w);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        bus.out_ready = 1'b1;
        while (q.size() != 0 && guard < 200) begin
            idle(1);
            guard++;
        end
        idle(1);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual=%0d required=0 pending", q.size());
        end
    endtask

    function automatic logic [127:0] rand_word();
        logic [127:0] w;
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 3) == 0) w[k*16 +: 16] = 16'($urandom);
            else w[k*16 +: 16] = 16'($urandom_range(0, 8191) - 4096);
        end
        return w;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst           = 1'b0;
        clear         = 1'b0;
        bias          = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) tb_ch[k] = '0;
        idle(3);
        rst = 1'b1;
        idle(2);

        bias = {16'd512, 112'd0};
        send_n(9, {16'd1024, 112'd0});
        drain();

        bias = '0;
        send_n(9, {8{16'h7fff}});
        drain();
        send_n(9, {8{16'hfc00}});
        drain();

        bus.out_ready = 1'b0;
        for (int i = 0; i < 9; i++) send_beat(rand_word());
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [127:0] g;
            g = rand_word();
            for (int k = 0; k < 8; k++) tb_ch[k] = g[(7-k)*16 +: 16];
            idle(1);
        end
        bus.in_valid = 1'b0;
        drain();

        send_n(4, {8{16'd1024}});
        idle(3);
        send_n(5, {8{16'd1024}});
        drain();

        send_n(4, {8{16'd2048}});
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        send_n(9, {8{16'd1024}});
        drain();

        send_n(4, {8{16'd2048}});
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        send_n(9, {8{16'd1024}});
        drain();

        bus.out_ready = 1'b0;
        send_n(9, {8{16'd3000}});
        idle(2);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        drain();

        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        bias = rand_word();
        d0 = done_seen;
        for (int p = 0; p < 900; p++) begin
            for (int b = 0; b < 9; b++) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                send_beat(rand_word());
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        drain();
        chk("layer_done_pulses", 128'(done_seen - d0), 128'(1));
        chk("pixel_cnt_wrap", 128'(pixel_cnt), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
